// File: rtl/opll_channel_mixer_pkg.sv
// Shared types and constants for the VM2413 output-path channel mixer.
package opll_channel_mixer_pkg;

  localparam int unsigned SLOT_W   = 5;
  localparam int unsigned LI_MAG_W = 9;
  localparam int unsigned ACC_W    = 15;
  localparam int unsigned SUM_W    = 16;

  typedef logic [SLOT_W-1:0] SLOT_TYPE;

  typedef struct packed {
    logic                sign;
    logic [LI_MAG_W-1:0] value;
  } SIGNED_LI_TYPE;

  typedef logic signed [ACC_W-1:0] MIX_ACC_TYPE;

  localparam SLOT_TYPE RHY_FIRST_SLOT = SLOT_TYPE'(12);
  localparam SLOT_TYPE BD_SLOT        = SLOT_TYPE'(13);
  localparam SLOT_TYPE HH_SLOT        = SLOT_TYPE'(14);
  localparam SLOT_TYPE SD_SLOT        = SLOT_TYPE'(15);
  localparam SLOT_TYPE TOM_SLOT       = SLOT_TYPE'(16);
  localparam SLOT_TYPE CYM_SLOT       = SLOT_TYPE'(17);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } mix_state_e;

endpackage

// File: rtl/opll_channel_mixer_li_to_signed.sv
// Sign-magnitude slot output to two's complement; negative zero maps to 0.
module li_to_signed
  import opll_channel_mixer_pkg::*;
(
  input  SIGNED_LI_TYPE               li_i,
  output logic signed [LI_MAG_W:0]    value_c_o
);

  logic signed [LI_MAG_W:0] mag_s;

  always_comb begin
    mag_s     = $signed({1'b0, li_i.value});
    value_c_o = li_i.sign ? -mag_s : mag_s;
  end

endmodule

// File: rtl/opll_channel_mixer.sv
// Per-frame scan of all slot results, summed into melody/rhythm buses and a saturated mix.
module opll_channel_mixer
  import opll_channel_mixer_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 18,
  parameter int unsigned OUT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clkena,
  input  logic                    frame_start,
  input  logic                    rhythm,
  output SLOT_TYPE                addr2,
  input  SIGNED_LI_TYPE           rdata2,
  output MIX_ACC_TYPE             mel_out,
  output MIX_ACC_TYPE             rhy_out,
  output logic signed [OUT_W-1:0] mix_out,
  output logic                    sample_valid,
  output logic                    overrun
);

  localparam SLOT_TYPE LAST_IDX  = SLOT_TYPE'(NUM_SLOTS - 1);
  localparam int       MIX_MAX_I = int'((1 << (OUT_W - 1)) - 1);
  localparam int       MIX_MIN_I = -int'(1 << (OUT_W - 1));
  localparam logic signed [SUM_W-1:0] MIX_MAX = SUM_W'(MIX_MAX_I);
  localparam logic signed [SUM_W-1:0] MIX_MIN = SUM_W'(MIX_MIN_I);

  mix_state_e               state_q, state_d;
  SLOT_TYPE                 rd_idx_q, rd_idx_d;
  MIX_ACC_TYPE              mel_acc_q, mel_acc_d;
  MIX_ACC_TYPE              rhy_acc_q, rhy_acc_d;
  logic                     rhy_l_q, rhy_l_d;
  MIX_ACC_TYPE              mel_q, mel_d;
  MIX_ACC_TYPE              rhy_q, rhy_d;
  logic signed [OUT_W-1:0]  mix_q, mix_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;

  logic signed [LI_MAG_W:0] slot_val_c;
  MIX_ACC_TYPE              term_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic signed [SUM_W-1:0]  sat_c;

  li_to_signed u_conv (
    .li_i      (rdata2),
    .value_c_o (slot_val_c)
  );

  assign term_c = MIX_ACC_TYPE'(slot_val_c);

  // Mix of the finished accumulators, clamped to the output width.
  always_comb begin
    sum_c = $signed({mel_acc_q[ACC_W-1], mel_acc_q}) + $signed({rhy_acc_q[ACC_W-1], rhy_acc_q});
    sat_c = sum_c;
    if (sum_c > MIX_MAX) begin
      sat_c = MIX_MAX;
    end else if (sum_c < MIX_MIN) begin
      sat_c = MIX_MIN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_idx_q  <= '0;
      mel_acc_q <= '0;
      rhy_acc_q <= '0;
      rhy_l_q   <= 1'b0;
      mel_q     <= '0;
      rhy_q     <= '0;
      mix_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_idx_q  <= rd_idx_d;
      mel_acc_q <= mel_acc_d;
      rhy_acc_q <= rhy_acc_d;
      rhy_l_q   <= rhy_l_d;
      mel_q     <= mel_d;
      rhy_q     <= rhy_d;
      mix_q     <= mix_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // rd_idx_q names the slot whose data is on rdata2 at the current enabled edge.
  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    mel_acc_d = mel_acc_q;
    rhy_acc_d = rhy_acc_q;
    rhy_l_d   = rhy_l_q;
    mel_d     = mel_q;
    rhy_d     = rhy_q;
    mix_d     = mix_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    if (clkena) begin
      if (frame_start && (state_q != ST_IDLE)) begin
        overrun_d = 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_d   = ST_SCAN;
            rd_idx_d  = '0;
            mel_acc_d = '0;
            rhy_acc_d = '0;
            rhy_l_d   = rhythm;
          end
        end
        ST_SCAN: begin
          if (rd_idx_q[0] && (!rhy_l_q || (rd_idx_q < RHY_FIRST_SLOT))) begin
            mel_acc_d = mel_acc_q + term_c;
          end
          if (rhy_l_q && (rd_idx_q >= BD_SLOT) && (rd_idx_q <= CYM_SLOT)) begin
            rhy_acc_d = rhy_acc_q + (term_c <<< 1);
          end
          if (rd_idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            rd_idx_d = rd_idx_q + SLOT_TYPE'(1);
          end
        end
        ST_DONE: begin
          mel_d   = mel_acc_q;
          rhy_d   = rhy_acc_q;
          mix_d   = OUT_W'(sat_c);
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign addr2        = rd_idx_q;
  assign mel_out      = mel_q;
  assign rhy_out      = rhy_q;
  assign mix_out      = mix_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_opll_channel_mixer.sv
// Directed bench for opll_channel_mixer: 16-bit and 12-bit output instances on a shared slot memory.
module tb_opll_channel_mixer;
  import opll_channel_mixer_pkg::*;

  logic clk;
  logic clkena, rhythm;
  logic reset_a, reset_b, fs_a, fs_b;
  SLOT_TYPE addr_a, addr_b;
  SIGNED_LI_TYPE rdata_a, rdata_b;
  MIX_ACC_TYPE mel_a, rhy_a, mel_b, rhy_b;
  logic signed [15:0] mix_a;
  logic signed [11:0] mix_b;
  logic sv_a, sv_b, ovr_a, ovr_b;

  SIGNED_LI_TYPE mem [0:31];

  int n_cmp = 0;
  int n_err = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  opll_channel_mixer dut_a (
    .clk(clk), .reset(reset_a), .clkena(clkena), .frame_start(fs_a), .rhythm(rhythm),
    .addr2(addr_a), .rdata2(rdata_a), .mel_out(mel_a), .rhy_out(rhy_a), .mix_out(mix_a),
    .sample_valid(sv_a), .overrun(ovr_a)
  );

  opll_channel_mixer #(.OUT_W(12)) dut_b (
    .clk(clk), .reset(reset_b), .clkena(clkena), .frame_start(fs_b), .rhythm(rhythm),
    .addr2(addr_b), .rdata2(rdata_b), .mel_out(mel_b), .rhy_out(rhy_b), .mix_out(mix_b),
    .sample_valid(sv_b), .overrun(ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered read port; updated mid-cycle so data for addr2=k is stable at the following enabled edge.
  always @(negedge clk) begin
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (sv_a) pulses_a++;
    if (sv_b) pulses_b++;
  endtask

  task automatic fill_all(input logic s, input int m);
    for (int i = 0; i < 32; i++) mem[i] = '{sign: s, value: 9'(m)};
  endtask

  // Accepts a frame on one instance and waits (bounded) for its sample_valid; checks latency of 19 edges.
  task automatic run_frame(input bit use_b, input logic rhy);
    int n;
    bit got;
    clkena = 1'b1;
    rhythm = rhy;
    if (use_b) fs_b = 1'b1; else fs_a = 1'b1;
    tick();
    fs_a = 1'b0;
    fs_b = 1'b0;
    rhythm = ~rhy;
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      got = use_b ? sv_b : sv_a;
    end
    chk("frame_done", 32'(got), 32'sd1);
    chk("latency", n, 19);
  endtask

  task automatic en3(input logic fs);
    clkena = 1'b0;
    tick();
    tick();
    clkena = 1'b1;
    fs_a = fs;
    tick();
    fs_a = 1'b0;
    clkena = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    clkena = 1'b0; rhythm = 1'b0; fs_a = 1'b0; fs_b = 1'b0;
    reset_a = 1'b1; reset_b = 1'b1;
    fill_all(1'b0, 100);
    tick(); tick();
    chk("rst_mel", mel_a, 0);
    chk("rst_mix", mix_a, 0);
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_sv", 32'(sv_a), 0);
    chk("rst_ovr", 32'(ovr_a), 0);
    chk("rst_mix_b", mix_b, 0);
    reset_a = 1'b0; reset_b = 1'b0;
    tick();

    // Melody, +100 everywhere, with address stepping
    clkena = 1'b1;
    fs_a = 1'b1;
    tick();
    fs_a = 1'b0;
    chk("addr_e0", 32'(addr_a), 0);
    for (int k = 1; k < 18; k++) begin
      tick();
      chk($sformatf("addr_e%0d", k), 32'(addr_a), k);
    end
    tick();
    chk("sv_e18", 32'(sv_a), 0);
    tick();
    chk("sv_e19", 32'(sv_a), 1);
    chk("t1_mel", mel_a, 900);
    chk("t1_rhy", rhy_a, 0);
    chk("t1_mix", mix_a, 900);
    tick();
    chk("sv_clear", 32'(sv_a), 0);

    // Melody, odd -511, even +511
    for (int i = 0; i < 32; i++) mem[i] = (i % 2 == 1) ? '{sign: 1'b1, value: 9'd511} : '{sign: 1'b0, value: 9'd511};
    run_frame(1'b0, 1'b0);
    chk("t2_mel", mel_a, -4599);
    chk("t2_rhy", rhy_a, 0);
    chk("t2_mix", mix_a, -4599);

    // Rhythm mode: odd 1..11 = 10, slot 12 = 500, 13..17 = 100, other even = 77
    for (int i = 0; i < 32; i++) begin
      if (i >= 13) mem[i] = '{sign: 1'b0, value: 9'd100};
      else if (i == 12) mem[i] = '{sign: 1'b0, value: 9'd500};
      else if (i % 2 == 1) mem[i] = '{sign: 1'b0, value: 9'd10};
      else mem[i] = '{sign: 1'b0, value: 9'd77};
    end
    run_frame(1'b0, 1'b1);
    chk("t3_mel", mel_a, 60);
    chk("t3_rhy", rhy_a, 1000);
    chk("t3_mix", mix_a, 1060);
    chk("t3_ovr", 32'(ovr_a), 0);

    // 12-bit saturation, both polarities
    fill_all(1'b0, 511);
    run_frame(1'b1, 1'b1);
    chk("t4p_mel", mel_b, 3066);
    chk("t4p_rhy", rhy_b, 5110);
    chk("t4p_mix", mix_b, 2047);
    fill_all(1'b1, 511);
    run_frame(1'b1, 1'b1);
    chk("t4n_mel", mel_b, -3066);
    chk("t4n_rhy", rhy_b, -5110);
    chk("t4n_mix", mix_b, -2048);
    chk("t4_ovr", 32'(ovr_b), 0);

    // Sparse clkena, negative zero, overlapping frame_start at E5
    fill_all(1'b1, 0);
    rhythm = 1'b0;
    snap = pulses_a;
    en3(1'b1);
    for (int e = 1; e <= 18; e++) en3(e == 5);
    chk("t5_sv_early", pulses_a - snap, 0);
    en3(1'b0);
    chk("t5_sv_e19", 32'(sv_a), 1);
    chk("t5_mel", mel_a, 0);
    chk("t5_mix", mix_a, 0);
    for (int e = 0; e < 25; e++) en3(1'b0);
    chk("t5_pulses", pulses_a - snap, 1);
    chk("t5_ovr", 32'(ovr_a), 1);

    // Reset mid-scan at E10
    fill_all(1'b0, 100);
    clkena = 1'b1;
    fs_a = 1'b1;
    tick();
    fs_a = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    reset_a = 1'b1;
    #1;
    chk("t6_mel", mel_a, 0);
    chk("t6_mix", mix_a, 0);
    chk("t6_addr", 32'(addr_a), 0);
    chk("t6_ovr", 32'(ovr_a), 0);
    snap = pulses_a;
    tick(); tick(); tick();
    reset_a = 1'b0;
    for (int e = 0; e < 25; e++) tick();
    chk("t6_no_sv", pulses_a - snap, 0);
    chk("t6_idle_addr", 32'(addr_a), 0);
    run_frame(1'b0, 1'b0);
    chk("t6_mel_after", mel_a, 900);
    chk("t6_mix_after", mix_a, 900);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/opll_channel_mixer.md
Name: opll_channel_mixer

Overview:
- Downstream consumer of the per-slot output memory's second read port (addr2/rdata2) in the VM2413 core.
- Once per frame, scans all 18 slot results and converts each from sign-magnitude to two's complement.
- Sums carrier slots into a melody bus and, in rhythm mode, the percussion slots into a rhythm bus.
- Publishes one mixed audio sample per frame with a valid pulse. This is the block that feeds the DAC/filter path.

Parameters:
- NUM_SLOTS, 18, slots scanned per frame; the read index runs 0..NUM_SLOTS-1.
- OUT_W, 16, width of the signed mixed output; the result saturates when narrower than 16.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- clkena  in  1  state advances only on clk edges where clkena=1
- frame_start  in  1  request to start a scan; sampled on enabled edges
- rhythm  in  1  rhythm-mode flag; sampled at frame accept
- addr2  out  5 (SLOT_TYPE)  read address to the output memory second port
- rdata2  in  10 (SIGNED_LI_TYPE: sign + 9-bit magnitude)  memory data; registered, 1 clk latency
- mel_out  out  15 signed  melody sum
- rhy_out  out  15 signed  rhythm sum
- mix_out  out  OUT_W signed  mel_out + rhy_out, saturated
- sample_valid  out  1  high for one clk after outputs update
- overrun  out  1  sticky; set when a frame_start is ignored

Behaviour:
- Reset (asynchronous): state=IDLE, addr2=0, all sums and outputs 0, sample_valid=0, overrun=0. Reset in the middle of a scan abandons the scan and does not output a partial sum.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - Enabled edge with frame_start=1 (edge E0) → SCAN.
  - At E0: clear both accumulators, set rd_idx=0, latch rhythm into rhy_l.
- addr2 = rd_idx register. rd_idx holds k from E(k) to E(k+1).
- SCAN:
  - At edge E(k+1), k=0..17, rdata2 is the value for slot k; accumulate it.
  - rd_idx increments, saturating at 17.
  - At E18 (slot 17 accumulated) → DONE.
  - rdata2 is captured only on enabled edges. Because addr2 changes only on enabled edges, any clkena pattern is correct.
- DONE, at E19:
  - mel_out <= melody accumulator; rhy_out <= rhythm accumulator.
  - mix_out <= sat(mel+rhy, OUT_W).
  - sample_valid <= 1; → IDLE.
  - sample_valid clears on the next clk edge. Outputs hold until the next DONE.
- Latency: outputs are valid 19 enabled edges after frame accept. The minimum frame period is 20 enabled cycles.
- Conversion: value = sign ? −mag : +mag. Negative zero (sign=1, mag=0) gives 0.
- Slot mapping: slot 2c is the modulator and 2c+1 the carrier of channel c (c = 0..8).
- rhy_l=0: melody sums the odd slots 1..17 (9 carriers). Even slots are discarded. The rhythm sum stays 0.
- rhy_l=1:
  - Melody sums odd slots 1..11 (channels 0..5).
  - Rhythm sums slots 13 (BD), 14 (HH), 15 (SD), 16 (TOM) and 17 (CYM), each term shifted left by 1.
  - Slot 12 is discarded.
- Widths: melody maximum is |9×511| = 4599; rhythm maximum is |5×1022| = 5110. 15-bit signed accumulators therefore never overflow. mix is computed at 16 bits, then clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- frame_start on an enabled edge while in SCAN or DONE: ignored, overrun <= 1. The bit is cleared only by reset.
- frame_start on the same edge that DONE→IDLE is not accepted; it sets overrun.
- rhythm changes during a scan have no effect until the next accept.

Decomposition:
- vm2413 package: SLOT_TYPE and SIGNED_LI_TYPE (existing).
- New in the package: MIX_ACC_TYPE (signed 15-bit); constants BD_SLOT=13, HH_SLOT=14, SD_SLOT=15, TOM_SLOT=16, CYM_SLOT=17, RHY_FIRST_SLOT=12.
- One sub-module, li_to_signed: combinational sign-magnitude to two's-complement converter. It is reused by other output-path stages.

Test Plan:
- Melody mode; memory holds +100 on all 18 slots; one frame_start, clkena=1 → sample_valid at E19; mel_out=900, rhy_out=0, mix_out=900; addr2 steps 0..17.
- Melody mode; odd slots = (sign=1, mag 511), even slots = +511 → mel_out=−4599, mix_out=−4599; even slots confirmed ignored.
- Rhythm mode; slots 1..11 odd = +10, slots 13..17 = +100, slot 12 = +500 → mel_out=60, rhy_out=1000, mix_out=1060.
- OUT_W=12; rhythm mode; all slots +511 → mel_out=3066, rhy_out=5110, mix_out saturates to 2047. A negative variant (all slots sign=1, mag 511) saturates to −2048.
- clkena high every 3rd clk; negative-zero on all slots; second frame_start at E5 → mix_out=0 after 19 enabled edges; overrun=1; no second sample_valid.
- Assert reset at E10 of a scan → outputs stay 0, state IDLE, no sample_valid. The next frame after release produces the correct sum.
